time_sync_core: RTL
===================

Name: time_sync_core

Overview:
- Local timebase engine that sits directly behind the time_sync AXI4-Lite register slave.
- Consumes commands decoded from the slave registers: set, step, rate trim, arm compare.
- Maintains a free-running 64-bit nanosecond clock with a fractional rate trim.
- Timestamps external events (packet/sample strobes) and produces a one-shot compare pulse that the streamer uses for scheduled playout.

Parameters:
TIME_W, 64, integer time width (ns)
FRAC_W, 32, fractional accumulator width
INC_INT, 10, nominal ns per ACLK cycle (100 MHz)

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  command accept
cmd_op  in  2  00 SET, 01 STEP, 10 TRIM, 11 ARM
cmd_data  in  TIME_W  command operand
time_now  out  TIME_W  current integer time
trim_q  out  32  active signed trim (Q0.FRAC_W ns/cycle)
evt_in  in  1  synchronous event level; a rising edge captures
evt_ts  out  TIME_W  captured timestamp
evt_valid  out  1  capture pending
evt_ack  in  1  consumer acknowledge
evt_ovf  out  1  sticky overrun flag
armed  out  1  compare armed
cmp_pulse  out  1  one-cycle compare strobe

Behaviour:
- Clock/reset: one clock, ACLK. Reset ARESETN is asynchronous and active-low.
- Reset values: all outputs 0 except cmd_ready=1. Internal state: frac=0, state=IDLE, cmp_time=0, evt_d=0.
- Reset mid-operation: any pending command is dropped and all state is cleared immediately.
- Accumulator {time_now,frac} (TIME_W+FRAC_W bits):
  - Each cycle adds (INC_INT<<FRAC_W) + sext(trim_q).
  - Wraps modulo 2^(TIME_W+FRAC_W); no saturation.
- Command FSM, IDLE -> APPLY -> IDLE:
  - cmd_ready = (state==IDLE).
  - Accept at edge N when cmd_valid && cmd_ready; op and data are registered.
  - APPLY takes effect at edge N+1, then returns to IDLE. Throughput is 1 command per 2 cycles.
- SET: at N+1, time_now<=cmd_data, frac<=0. The load replaces that cycle's increment.
- STEP: at N+1, time_now<=time_now+INC_INT+carry+sext(cmd_data[31:0]); frac advances normally.
- TRIM: trim_q<=cmd_data[31:0] at N+1. The first increment using the new trim is at edge N+2.
- ARM:
  - cmp_time<=cmd_data, armed<=1 at N+1.
  - Re-ARM while armed replaces cmp_time.
- Compare:
  - Each cycle, if armed && time_now>=cmp_time (unsigned): cmp_pulse<=1 for exactly one cycle and armed<=0.
  - A past cmp_time, or a SET/STEP that jumps past it, fires on the next evaluation.
  - A wrap below cmp_time does not fire.
- Event capture:
  - rise = evt_in & ~evt_d.
  - On rise with !evt_valid, or with evt_valid && evt_ack in the same cycle: evt_ts<=time_now (value before this edge's update), evt_valid<=1.
  - On rise with evt_valid && !evt_ack: evt_ts is held and evt_ovf<=1.
  - evt_ack without rise: evt_valid<=0, evt_ovf<=0.
  - evt_ack while !evt_valid is ignored.
- Latency: time_now is registered. Event timestamp uncertainty is 1 cycle (INC_INT ns).

Decomposition:
- Shared package time_sync_pkg holds:
  - cmd_op enum (SET, STEP, TRIM, ARM)
  - TIME_W/FRAC_W/INC_INT defaults
  - FSM state typedef
- One sub-module: time_sync_evt_capture. It owns edge detect, evt_ts/evt_valid/evt_ovf and the ack handshake, and takes time_now as input.

Test Plan:
1. Release reset, trim 0 -> time_now = 0,10,20,…; after 5 cycles = 50; cmd_ready=1.
2. SET 0x1000 -> time_now=0x1000 at N+1. Then STEP cmd_data=0xFFFF_FFF0 -> next value = prev+10-16; cmd_ready low exactly one cycle per command.
3. TRIM 0x8000_0000 (-0.5 ns) from frac=0 -> increments alternate 9,10; +38 after 4 cycles. TRIM 0 restores +10.
4. time_now=0x1000, ARM 0x1064 -> cmp_pulse high exactly one cycle when time_now first reads 0x1064 (10 cycles later); armed drops. ARM 0x0FFF while at 0x2000 -> pulse on next cycle.
5. Two evt_in rising edges without ack -> evt_ts holds the first timestamp, evt_ovf=1. evt_ack -> evt_valid=0, evt_ovf=0. Rise coincident with ack -> new capture, evt_valid stays 1.
6. SET 0xFFFF_FFFF_FFFF_FFFB -> next cycle time_now=5 (wrap). Assert ARESETN=0 during APPLY of a SET -> all outputs reset immediately; SET not applied after release.

Source files
------------

// File: rtl/time_sync_pkg.sv
// Shared types and default sizing for the local timebase engine.
package time_sync_pkg;

    localparam int TIME_W_DEF  = 64;
    localparam int FRAC_W_DEF  = 32;
    localparam int INC_INT_DEF = 10;
    localparam int TRIM_W      = 32;

    typedef enum logic [1:0] {
        OP_SET  = 2'b00,
        OP_STEP = 2'b01,
        OP_TRIM = 2'b10,
        OP_ARM  = 2'b11
    } cmd_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/time_sync_if.sv
// Command, status and event-capture signals between the register slave and the timebase.
interface time_sync_if
    import time_sync_pkg::*;
#(
    parameter int TIME_W = TIME_W_DEF
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    cmd_op_e           cmd_op;
    logic [TIME_W-1:0] cmd_data;

    logic [TIME_W-1:0] time_now;
    logic [TRIM_W-1:0] trim_q;

    logic              evt_in;
    logic [TIME_W-1:0] evt_ts;
    logic              evt_valid;
    logic              evt_ack;
    logic              evt_ovf;

    logic              armed;
    logic              cmp_pulse;

    modport master (
        output cmd_valid, cmd_op, cmd_data, evt_in, evt_ack,
        input  cmd_ready, time_now, trim_q, evt_ts, evt_valid, evt_ovf, armed, cmp_pulse
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, evt_in, evt_ack,
        output cmd_ready, time_now, trim_q, evt_ts, evt_valid, evt_ovf, armed, cmp_pulse
    );

endinterface

// File: rtl/time_sync_evt_capture.sv
// Rising-edge event timestamping with a single-entry holding register and sticky overrun.
module time_sync_evt_capture
    import time_sync_pkg::*;
#(
    parameter int TIME_W = TIME_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_evt_in,
    input  logic              i_evt_ack,
    input  logic [TIME_W-1:0] i_time_now,
    output logic [TIME_W-1:0] o_evt_ts,
    output logic              o_evt_valid,
    output logic              o_evt_ovf
);

    logic              r_evt_d;
    logic [TIME_W-1:0] r_evt_ts;
    logic              r_evt_valid;
    logic              r_evt_ovf;
    logic              w_rise;

    assign w_rise = i_evt_in & ~r_evt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_d     <= 1'b0;
            r_evt_ts    <= '0;
            r_evt_valid <= 1'b0;
            r_evt_ovf   <= 1'b0;
        end else begin
            r_evt_d <= i_evt_in;
            // An ack in the same cycle frees the slot, so the new edge is captured, not lost
            if (w_rise && (!r_evt_valid || i_evt_ack)) begin
                r_evt_ts    <= i_time_now;
                r_evt_valid <= 1'b1;
                r_evt_ovf   <= 1'b0;
            end else if (w_rise) begin
                r_evt_ovf <= 1'b1;
            end else if (i_evt_ack && r_evt_valid) begin
                r_evt_valid <= 1'b0;
                r_evt_ovf   <= 1'b0;
            end
        end
    end

    assign o_evt_ts    = r_evt_ts;
    assign o_evt_valid = r_evt_valid;
    assign o_evt_ovf   = r_evt_ovf;

endmodule

// File: rtl/time_sync_core.sv
// Free-running ns timebase with fractional trim, command sequencer, compare strobe and event capture.
//   state    | meaning
//   ST_IDLE  | cmd_ready high, waiting for a command
//   ST_APPLY | registered command takes effect on this edge
module time_sync_core
    import time_sync_pkg::*;
#(
    parameter int TIME_W  = TIME_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int INC_INT = INC_INT_DEF
) (
    input  logic       ACLK,
    input  logic       ARESETN,
    time_sync_if.slave bus
);

    localparam int               ACC_W   = TIME_W + FRAC_W;
    localparam logic [ACC_W-1:0] INC_FIX = ACC_W'(INC_INT) << FRAC_W;

    fsm_state_e        r_state;
    fsm_state_e        w_state_next;
    logic              w_accept;
    logic              w_apply;
    cmd_op_e           r_op;
    logic [TIME_W-1:0] r_data;

    logic [TIME_W-1:0] r_time;
    logic [FRAC_W-1:0] r_frac;
    logic [TRIM_W-1:0] r_trim;
    logic [TIME_W-1:0] r_cmp_time;
    logic              r_armed;
    logic              r_cmp_pulse;

    logic [ACC_W-1:0]  w_trim_ext;
    logic [ACC_W-1:0]  w_acc_sum;
    logic [TIME_W-1:0] w_step_ext;
    logic              w_cmp_hit;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_apply      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_APPLY;
                end
            end
            ST_APPLY: begin
                w_apply      = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= ST_IDLE;
            r_op    <= OP_SET;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op   <= bus.cmd_op;
                r_data <= bus.cmd_data;
            end
        end
    end

    assign w_trim_ext = {{(ACC_W-TRIM_W){r_trim[TRIM_W-1]}}, r_trim};
    assign w_acc_sum  = {r_time, r_frac} + INC_FIX + w_trim_ext;
    assign w_step_ext = {{(TIME_W-32){r_data[31]}}, r_data[31:0]};

    // STEP rides on top of the normal increment so the fractional phase is preserved
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_time <= '0;
            r_frac <= '0;
        end else if (w_apply && (r_op == OP_SET)) begin
            r_time <= r_data;
            r_frac <= '0;
        end else if (w_apply && (r_op == OP_STEP)) begin
            r_time <= w_acc_sum[ACC_W-1:FRAC_W] + w_step_ext;
            r_frac <= w_acc_sum[FRAC_W-1:0];
        end else begin
            {r_time, r_frac} <= w_acc_sum;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_trim <= '0;
        end else if (w_apply && (r_op == OP_TRIM)) begin
            r_trim <= r_data[TRIM_W-1:0];
        end
    end

    assign w_cmp_hit = r_armed && (r_time >= r_cmp_time);

    // A fresh ARM wins over a hit on the old target
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_cmp_time  <= '0;
            r_armed     <= 1'b0;
            r_cmp_pulse <= 1'b0;
        end else begin
            r_cmp_pulse <= w_cmp_hit;
            if (w_apply && (r_op == OP_ARM)) begin
                r_cmp_time <= r_data;
                r_armed    <= 1'b1;
            end else if (w_cmp_hit) begin
                r_armed <= 1'b0;
            end
        end
    end

    time_sync_evt_capture #(
        .TIME_W (TIME_W)
    ) u_evt_capture (
        .clk         (ACLK),
        .rst_n       (ARESETN),
        .i_evt_in    (bus.evt_in),
        .i_evt_ack   (bus.evt_ack),
        .i_time_now  (r_time),
        .o_evt_ts    (bus.evt_ts),
        .o_evt_valid (bus.evt_valid),
        .o_evt_ovf   (bus.evt_ovf)
    );

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.time_now  = r_time;
    assign bus.trim_q    = r_trim;
    assign bus.armed     = r_armed;
    assign bus.cmp_pulse = r_cmp_pulse;

endmodule
